// File: rtl/phys_free_list_pkg.sv
// Shared types and sizing for the physical-register free list.
// Holds the ROB entry fields that the free list reads and the consumes_reg() predicate.
package phys_free_list_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PHYS_W   = $clog2(NUM_PHYS);
    localparam int ARCH_W   = $clog2(NUM_ARCH);
    // The depth must be a power of two so that the head pointers can wrap naturally.
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int FL_W     = $clog2(FL_DEPTH);
    localparam int CNT_W    = FL_W + 1;

    typedef logic [PHYS_W-1:0] preg_t;
    typedef logic [ARCH_W-1:0] areg_t;

    typedef struct packed {
        logic  uses_rd;
        areg_t rd_arch;
        preg_t pd_old;
        preg_t pd_new;
    } rob_entry_t;

    // Writes to x0 never take a physical register.
    function automatic logic consumes_reg(input rob_entry_t e);
        return e.uses_rd && (e.rd_arch != '0);
    endfunction

endpackage

// File: rtl/phys_free_list_fl_check.sv
// Consistency checker for the free list: it tracks which physical registers are free.
// It raises a sticky fl_error on a double free, a push of p0, a walk-back mismatch or a counter saturation.
module phys_free_list_fl_check
    import phys_free_list_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_fire,
    input  logic            commit_push,
    input  preg_t           commit_preg,
    input  logic            recover_pop,
    input  preg_t           recover_preg,
    input  logic            flush_valid,
    input  logic [FL_W-1:0] spec_head,
    input  logic [FL_W-1:0] retire_head,
    input  preg_t           slots [FL_DEPTH],
    input  logic            cnt_sat,
    output logic            fl_error
);

    logic [NUM_PHYS-1:0] in_free;
    logic [NUM_PHYS-1:0] in_free_nxt;
    logic [FL_W-1:0]     spec_prev;
    logic [FL_W-1:0]     idx;
    preg_t               slot_val;
    logic                err_now;

    assign spec_prev = spec_head - FL_W'(1);

    always_comb begin
        // NOTE: every variable gets a default first, so that no path can infer a latch.
        in_free_nxt = in_free;
        err_now     = cnt_sat;
        idx         = '0;
        slot_val    = '0;

        if (alloc_fire)
            in_free_nxt[slots[spec_head]] = 1'b0;

        if (commit_push) begin
            if (in_free[commit_preg] || (commit_preg == '0))
                err_now = 1'b1;
            in_free_nxt[commit_preg] = 1'b1;
        end

        if (recover_pop) begin
            if ((recover_preg != slots[spec_prev]) || in_free[recover_preg] || (recover_preg == '0))
                err_now = 1'b1;
            in_free_nxt[recover_preg] = 1'b1;
        end

        // After a flush, every slot of the committed window holds a free register.
        // This includes the slot that a same-cycle commit writes.
        if (flush_valid) begin
            in_free_nxt = '0;
            for (int k = 0; k < FL_DEPTH; k++) begin
                idx      = retire_head + FL_W'(k);
                slot_val = (commit_push && (idx == retire_head)) ? commit_preg : slots[idx];
                in_free_nxt[slot_val] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_free  <= {{FL_DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
            fl_error <= 1'b0;
        end else begin
            in_free <= in_free_nxt;
            if (err_now)
                fl_error <= 1'b1;
        end
    end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical destination registers for rename: it allocates, reclaims on commit, walks back and flushes.
// Build with FREE_LIST_CHECK_EN defined to add the fl_error consistency checker.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int PHYS_W_P = PHYS_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req,
    output logic                alloc_ready,
    output logic [PHYS_W_P-1:0] alloc_preg,
    input  logic                commit_fire,
    input  rob_entry_t          commit_entry,
    input  logic                recover_valid,
    input  rob_entry_t          recover_entry,
    input  logic                flush_valid,
    output logic [CNT_W-1:0]    free_count
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                fl_error
`endif
);

    localparam int CNTX_W = CNT_W + 1;

    preg_t            mem [FL_DEPTH];
    logic [FL_W-1:0]  spec_head;
    logic [FL_W-1:0]  retire_head;
    logic [FL_W-1:0]  retire_head_nxt;
    logic [CNT_W-1:0] spec_count;
    logic [CNT_W-1:0] spec_count_nxt;
    logic             alloc_fire;
    logic             commit_push;
    logic             recover_pop;
    logic [CNTX_W-1:0] cnt_up;
    logic [CNTX_W-1:0] cnt_net;
    logic             cnt_underflow;
    logic             cnt_overflow;
    logic             unused_pd_new;

    assign unused_pd_new = ^{commit_entry.pd_new, recover_entry.pd_new};

    assign alloc_ready = (spec_count != '0) && !recover_valid && !flush_valid;
    assign alloc_preg  = PHYS_W_P'(mem[spec_head]);
    assign free_count  = spec_count;

    assign alloc_fire  = alloc_req && alloc_ready;
    assign commit_push = commit_fire && consumes_reg(commit_entry);
    // A flush squashes any walk-back step in the same cycle.
    assign recover_pop = recover_valid && consumes_reg(recover_entry) && !flush_valid;

    // The committed state always holds exactly FL_DEPTH free registers, so retire_head is also the push slot.
    assign retire_head_nxt = retire_head + FL_W'(commit_push);

    always_comb begin
        cnt_up        = {1'b0, spec_count} + CNTX_W'(commit_push) + CNTX_W'(recover_pop);
        cnt_underflow = alloc_fire && (cnt_up == '0);
        cnt_net       = cnt_up - CNTX_W'(alloc_fire);
        cnt_overflow  = !cnt_underflow && (cnt_net > CNTX_W'(FL_DEPTH));
        if (cnt_underflow)
            spec_count_nxt = '0;
        else if (cnt_overflow)
            spec_count_nxt = CNT_W'(FL_DEPTH);
        else
            spec_count_nxt = cnt_net[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset here, because its reset contents are the initial free list.
            for (int i = 0; i < FL_DEPTH; i++)
                mem[i] <= preg_t'(NUM_ARCH + i);
            spec_head   <= '0;
            retire_head <= '0;
            spec_count  <= CNT_W'(FL_DEPTH);
        end else begin
            // NOTE: all state updates are non-blocking, so every branch reads the values from before the edge.
            if (commit_push)
                mem[retire_head] <= commit_entry.pd_old;
            retire_head <= retire_head_nxt;
            if (flush_valid) begin
                spec_head  <= retire_head_nxt;
                spec_count <= CNT_W'(FL_DEPTH);
            end else begin
                spec_head  <= spec_head + FL_W'(alloc_fire) - FL_W'(recover_pop);
                spec_count <= spec_count_nxt;
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    phys_free_list_fl_check u_fl_check (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_fire   (alloc_fire),
        .commit_push  (commit_push),
        .commit_preg  (commit_entry.pd_old),
        .recover_pop  (recover_pop),
        .recover_preg (recover_entry.pd_new),
        .flush_valid  (flush_valid),
        .spec_head    (spec_head),
        .retire_head  (retire_head),
        .slots        (mem),
        .cnt_sat      (!flush_valid && (cnt_underflow || cnt_overflow)),
        .fl_error     (fl_error)
    );
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: a queue model of the free and in-flight registers feeds a grant scoreboard.
// Also checks fl_error when built with FREE_LIST_CHECK_EN.
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alloc_req;
    logic             alloc_ready;
    logic [PHYS_W-1:0] alloc_preg;
    logic             commit_fire;
    rob_entry_t       commit_entry;
    logic             recover_valid;
    rob_entry_t       recover_entry;
    logic             flush_valid;
    logic [CNT_W-1:0] free_count;
`ifdef FREE_LIST_CHECK_EN
    logic             fl_error;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int free_q[$];
    int infl_q[$];
    int exp_q[$];
    int obs_q[$];

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req     (alloc_req),
        .alloc_ready   (alloc_ready),
        .alloc_preg    (alloc_preg),
        .commit_fire   (commit_fire),
        .commit_entry  (commit_entry),
        .recover_valid (recover_valid),
        .recover_entry (recover_entry),
        .flush_valid   (flush_valid),
        .free_count    (free_count)
`ifdef FREE_LIST_CHECK_EN
        ,
        .fl_error      (fl_error)
`endif
    );

    function automatic rob_entry_t mk(input bit u, input int rd, input int po, input int pn);
        rob_entry_t e;
        e.uses_rd = u;
        e.rd_arch = areg_t'(rd);
        e.pd_old  = preg_t'(po);
        e.pd_new  = preg_t'(pn);
        return e;
    endfunction

    task automatic clear_inputs();
        alloc_req     = 1'b0;
        commit_fire   = 1'b0;
        commit_entry  = '0;
        recover_valid = 1'b0;
        recover_entry = '0;
        flush_valid   = 1'b0;
    endtask

    task automatic model_reset();
        free_q.delete();
        infl_q.delete();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < FL_DEPTH; i++)
            free_q.push_back(NUM_ARCH + i);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one cycle of stimulus. The expected grant (-1 means not ready) goes on exp_q.
    // The observed grant goes on obs_q, and the model advances.
    task automatic drive_cycle(input bit a, input bit c, input rob_entry_t ce,
                               input bit r, input rob_entry_t re, input bit f);
        bit ready_m;
        int p;
        @(negedge clk);
        alloc_req     = a;
        commit_fire   = c;
        commit_entry  = ce;
        recover_valid = r;
        recover_entry = re;
        flush_valid   = f;
        #1;
        ready_m = (free_q.size() > 0) && !r && !f;
        if (a) begin
            exp_q.push_back(ready_m ? free_q[0] : -1);
            obs_q.push_back(alloc_ready ? int'(alloc_preg) : -1);
        end
        if (c && ce.uses_rd && (ce.rd_arch != 0)) begin
            if (infl_q.size() > 0) void'(infl_q.pop_front());
            free_q.push_back(int'(ce.pd_old));
        end
        if (a && ready_m) begin
            p = free_q.pop_front();
            infl_q.push_back(p);
        end
        if (r && !f && re.uses_rd && (re.rd_arch != 0) && (infl_q.size() > 0)) begin
            p = infl_q.pop_back();
            free_q.push_front(p);
        end
        if (f) begin
            free_q = {infl_q, free_q};
            infl_q.delete();
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", alloc_ready); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(NUM_ARCH)) begin n_fail++; $display("FAIL reset_preg: got %0d want %0d", alloc_preg, NUM_ARCH); end
        n_checks++;
        if (free_count !== CNT_W'(FL_DEPTH)) begin n_fail++; $display("FAIL reset_count: got %0d want %0d", free_count, FL_DEPTH); end
`ifdef FREE_LIST_CHECK_EN
        n_checks++;
        if (fl_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b want 0", fl_error); end
`endif
    endtask

    task automatic test_back_to_back();
        int e, o;
        apply_reset();
        for (int i = 0; i < FL_DEPTH + 1; i++)
            drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", i, o, e); end
        end
        n_checks++;
        if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL empty_ready: got %0b want 0", alloc_ready); end
        n_checks++;
        if (free_count !== '0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", free_count); end
    endtask

    // Continues from the empty list that test_back_to_back leaves behind.
    task automatic test_commit_refill();
        drive_cycle(1'b0, 1'b1, mk(1, 3, 5, infl_q[0]), 1'b0, '0, 1'b0);
        n_checks++;
        if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready: got %0b want 1", alloc_ready); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(5)) begin n_fail++; $display("FAIL refill_preg: got %0d want 5", alloc_preg); end
        n_checks++;
        if (free_count !== CNT_W'(1)) begin n_fail++; $display("FAIL refill_count: got %0d want 1", free_count); end
    endtask

    task automatic test_recover();
        int e, o;
        apply_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, mk(1, 4, 0, infl_q[$]), 1'b0);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, mk(0, 0, 0, 0), 1'b0);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, mk(1, 2, 0, infl_q[$]), 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL recover_grant[%0d]: got %0d want %0d", i, o, e); end
        end
        n_checks++;
        if (alloc_preg !== PHYS_W'(34)) begin n_fail++; $display("FAIL recover_preg: got %0d want 34", alloc_preg); end
        n_checks++;
        if (free_count !== CNT_W'(30)) begin n_fail++; $display("FAIL recover_count: got %0d want 30", free_count); end
    endtask

    task automatic test_alloc_commit();
        int e, o;
        apply_reset();
        drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 1'b1, mk(1, 3, 3, infl_q[0]), 1'b0, '0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ac_grant[%0d]: got %0d want %0d", i, o, e); end
        end
        n_checks++;
        if (free_count !== CNT_W'(31)) begin n_fail++; $display("FAIL ac_count: got %0d want 31", free_count); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(34)) begin n_fail++; $display("FAIL ac_spec_head: got %0d want 34", alloc_preg); end
        // A flush exposes retire_head: it must now point at p33, the one register still in flight.
        drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        n_checks++;
        if (alloc_preg !== PHYS_W'(33)) begin n_fail++; $display("FAIL ac_retire_head: got %0d want 33", alloc_preg); end
        n_checks++;
        if (free_count !== CNT_W'(FL_DEPTH)) begin n_fail++; $display("FAIL ac_flush_count: got %0d want %0d", free_count, FL_DEPTH); end
    endtask

    task automatic test_commit_recover();
        apply_reset();
        repeat (4) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, mk(1, 7, 8, infl_q[0]), 1'b1, mk(1, 9, 0, infl_q[$]), 1'b0);
        exp_q.delete();
        obs_q.delete();
        n_checks++;
        if (free_count !== CNT_W'(30)) begin n_fail++; $display("FAIL cr_count: got %0d want 30", free_count); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(35)) begin n_fail++; $display("FAIL cr_preg: got %0d want 35", alloc_preg); end
    endtask

    task automatic test_flush();
        int e, o;
        apply_reset();
        repeat (10) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, mk(1, 1, 7, infl_q[0]), 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, mk(1, 2, 9, infl_q[0]), 1'b0, '0, 1'b0);
        // The recover and the alloc in the flush cycle must both be ignored.
        drive_cycle(1'b1, 1'b1, mk(1, 5, 11, infl_q[0]), 1'b1, mk(1, 6, 0, infl_q[$]), 1'b1);
        n_checks++;
        if (free_count !== CNT_W'(FL_DEPTH)) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", free_count, FL_DEPTH); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(35)) begin n_fail++; $display("FAIL flush_preg: got %0d want 35", alloc_preg); end
        repeat (FL_DEPTH) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL flush_grant[%0d]: got %0d want %0d", i, o, e); end
        end
    endtask

    task automatic test_double_free();
        apply_reset();
        @(negedge clk);
        commit_fire  = 1'b1;
        commit_entry = mk(1, 3, 40, 32);
        @(posedge clk);
        #1;
        clear_inputs();
        n_checks++;
        if (free_count !== CNT_W'(FL_DEPTH)) begin n_fail++; $display("FAIL df_count: got %0d want %0d", free_count, FL_DEPTH); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(40)) begin n_fail++; $display("FAIL df_preg: got %0d want 40", alloc_preg); end
`ifdef FREE_LIST_CHECK_EN
        n_checks++;
        if (fl_error !== 1'b1) begin n_fail++; $display("FAIL df_error: got %0b want 1", fl_error); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fl_error !== 1'b1) begin n_fail++; $display("FAIL df_sticky: got %0b want 1", fl_error); end
        apply_reset();
        n_checks++;
        if (fl_error !== 1'b0) begin n_fail++; $display("FAIL df_cleared: got %0b want 0", fl_error); end
`endif
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (3) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        recover_valid = 1'b1;
        recover_entry = mk(1, 1, 0, 34);
        flush_valid   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (free_count !== CNT_W'(FL_DEPTH)) begin n_fail++; $display("FAIL arst_count: got %0d want %0d", free_count, FL_DEPTH); end
        n_checks++;
        if (alloc_preg !== PHYS_W'(NUM_ARCH)) begin n_fail++; $display("FAIL arst_preg: got %0d want %0d", alloc_preg, NUM_ARCH); end
        n_checks++;
        if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready_blocked: got %0b want 0", alloc_ready); end
        clear_inputs();
        #1;
        n_checks++;
        if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b want 1", alloc_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_commit_refill();
        test_recover();
        test_alloc_commit();
        test_commit_recover();
        test_flush();
        test_double_free();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
- Circular free list of physical destination registers for the rename stage; directly upstream of the reorder buffer, it supplies the pd_new the ROB records at allocation.
- Reclaims pd_old when the ROB commits an entry.
- Returns pd_new one entry per cycle while the ROB walks back after a mispredict.
- Snaps back to the committed state on a pipeline flush.

Parameters:
- NUM_PHYS, 64, number of physical registers.
- NUM_ARCH, 32, number of architectural registers; arch i maps to phys i at reset.
- PHYS_W_P, PHYS_W, physical register index width.
- FL_DEPTH, NUM_PHYS-NUM_ARCH (32), free-list entries; must be a power of two.
- FL_W, $clog2(FL_DEPTH), pointer width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_req  in  1  rename consumes one register this cycle.
- alloc_ready  out  1  a free register is available.
- alloc_preg  out  PHYS_W_P  register granted on alloc_req && alloc_ready.
- commit_fire  in  1  ROB commit handshake completed (commit_valid && commit_ready).
- commit_entry  in  rob_entry_t  committed entry; uses uses_rd, rd_arch, pd_old, pd_new.
- recover_valid  in  1  ROB walk-back step for this cycle.
- recover_entry  in  rob_entry_t  entry being squashed (tail-1).
- flush_valid  in  1  full pipeline flush.
- free_count  out  FL_W+1  speculatively free registers.
- fl_error  out  1  consistency error, sticky; present only with FREE_LIST_CHECK_EN.

Behaviour:
- consumes(e) = e.uses_rd && (e.rd_arch != 0). The same predicate qualifies alloc (the requester applies it), commit and recover.
- State:
  - mem[FL_DEPTH] of PHYS_W_P.
  - spec_head, retire_head, FL_W bits each, wrap mod FL_DEPTH.
  - spec_count, FL_W+1 bits.
  - There is no separate tail. The push slot is always retire_head, because the committed state always holds exactly FL_DEPTH free registers.
- Reset:
  - mem[i]=NUM_ARCH+i; spec_head=retire_head=0; spec_count=FL_DEPTH.
  - Resulting outputs: alloc_ready=1, alloc_preg=NUM_ARCH, free_count=FL_DEPTH, fl_error=0.
- Outputs:
  - alloc_ready = (spec_count!=0) && !recover_valid && !flush_valid.
  - alloc_preg = mem[spec_head], combinational, zero-latency grant.
  - There is no bypass of a same-cycle freed register into an empty list.
- Alloc (alloc_req && alloc_ready): spec_head+1, spec_count-1.
- Commit (commit_fire && consumes(commit_entry)):
  - mem[retire_head] <= pd_old.
  - retire_head+1, spec_count+1.
  - Committing pd_new becomes permanently consumed. The write overwrites exactly the slot that held it.
- Recover (recover_valid && consumes(recover_entry)): spec_head-1, spec_count+1, returning the most recent pop (LIFO walk-back). Non-consuming entries cause no change.
- Simultaneous events:
  - Alloc+commit: both apply; spec_count is unchanged.
  - Commit+recover: both apply (they use different pointers); spec_count+2.
  - Alloc+recover: cannot both apply, since alloc_ready=0 during recover.
- Flush has top priority for speculative state:
  - A commit in the same cycle is still applied first.
  - Then spec_head <= retire_head (post-commit value) and spec_count <= FL_DEPTH.
  - Any recover or alloc in that cycle is ignored.
- Underflow/overflow are never legal.
  - spec_count saturates at 0 and FL_DEPTH (guarded).
  - With the check feature enabled, either condition raises fl_error.
- Asynchronous reset mid-recovery or mid-flush returns every register to its reset value in the same edge.

Optional Feature:
- FREE_LIST_CHECK_EN enables a NUM_PHYS-bit in_free vector (reset: bits NUM_ARCH..NUM_PHYS-1 set).
  - Alloc clears the bit; recover and commit-push set it.
  - fl_error is set when any of the following occurs:
    - a push of a register whose bit is already set (double free);
    - a recover whose recover_entry.pd_new != mem[spec_head-1];
    - a push of p0;
    - counter saturation.
  - fl_error clears only on reset.
  - Flush rebuilds in_free from the mem slots in the window retire_head..retire_head+FL_DEPTH-1.
- Without the macro: no vector, no fl_error port, no check logic.

Decomposition:
- Shared package (defines.svh):
  - NUM_PHYS, NUM_ARCH, PHYS_W, FL_DEPTH, FL_W;
  - the rob_entry_t fields used here;
  - a function consumes_reg(rob_entry_t).
- Sub-module fl_check holds the FREE_LIST_CHECK_EN logic, so it is instantiated only under the macro.

Test Plan:
- Reset, then 32 back-to-back allocs -> grants p32..p63 in order; alloc_ready drops after the 32nd; free_count=0.
- Empty list, commit with pd_old=p5 and uses_rd=1, rd_arch=3 -> next cycle alloc_ready=1, alloc_preg=p5, free_count=1.
- 4 allocs (p32..p35), then 3 recover steps, of which the middle one has uses_rd=0 -> spec_head back by 2; alloc_preg=p34; free_count=30.
- Alloc+commit in the same cycle with a full list minus one -> free_count unchanged; retire_head and spec_head both advance.
- 10 allocs, 2 commits (pd_old p7, p9), then flush with a concurrent 3rd commit (pd_old p11) -> free_count=32; alloc_preg is the pd_new following the 3rd commit's pd_new; subsequent grants then wrap through p7, p9, p11.
- With FREE_LIST_CHECK_EN: commit pushing p40 while p40 is free -> fl_error=1 next cycle and stays set until reset; without the macro, the same stimulus leaves behaviour otherwise identical.
